// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX-resolved redirects, data-memory wait
// freezes with a deferred redirect, and saturating stall/redirect counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, LU_STALL} state_t;

  state_t           state_q, state_d;
  logic             pend_v_q, pend_v_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [6:0] opcode;
  logic       rs1_use, rs2_use, lu_hazard, mem_wait;
  logic       unused_inst_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign opcode    = id_inst[6:0];
  assign rs1_use   = opcode inside {7'b0010011, 7'b0000011, 7'b0100011,
                                    7'b1100011, 7'b1100111, 7'b0110011};
  assign rs2_use   = opcode inside {7'b0100011, 7'b1100011, 7'b0110011};
  assign lu_hazard = ex_mem_read && (ex_rd != 5'd0) &&
                     ((rs1_use && (id_inst[19:15] == ex_rd)) ||
                      (rs2_use && (id_inst[24:20] == ex_rd)));
  assign mem_wait  = dmem_req && !dmem_ready;
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    pc_sel       = 1'b0;
    pc_target    = 32'd0;
    state_d      = RUN;
    pend_v_d     = pend_v_q;
    pend_tgt_d   = pend_tgt_q;

    case (state_q)
      MEM_WAIT: begin
        if (!dmem_ready) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
          mem_wb_flush = 1'b1;
          state_d      = MEM_WAIT;
        end else if (pend_v_q) begin
          // the redirect seen on entry was deferred until memory released the pipe
          pc_sel      = 1'b1;
          pc_target   = pend_tgt_q;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          pend_v_d    = 1'b0;
        end
      end
      default: begin
        if (mem_wait) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
          mem_wb_flush = 1'b1;
          state_d      = MEM_WAIT;
          if (ex_redirect) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = ex_target;
          end
        end else if (ex_redirect) begin
          pc_sel      = 1'b1;
          pc_target   = ex_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if ((state_q == RUN) && lu_hazard) begin
          // LU_STALL skips this check so a held hazard stalls exactly once
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = LU_STALL;
        end
      end
    endcase

    if (rst) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
      {if_id_flush, id_ex_flush, mem_wb_flush} = 3'b111;
      pc_sel    = 1'b0;
      pc_target = 32'd0;
    end

    stall_cnt_d = pc_we  ? stall_cnt_q : sat_inc(stall_cnt_q);
    flush_cnt_d = pc_sel ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pend_v_q    <= 1'b0;
      pend_tgt_q  <= 32'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_tgt_q  <= pend_tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each cycle's expected controls are queued as the
// stimulus is driven, then popped and compared against the combinational outputs.
module tb_pipe_ctrl;

  localparam int CW = 4;
  localparam logic [3:0] WE_ALL = 4'b1111, WE_NONE = 4'b0000, WE_LU = 4'b0011;
  localparam logic [2:0] FL_NONE = 3'b000, FL_RST = 3'b111, FL_RED = 3'b110,
                         FL_LU = 3'b010, FL_MEM = 3'b001;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADD_156  = 32'h0062_80B3; // add x1,x5,x6
  localparam logic [31:0] LUI_X0   = 32'h0000_0037;
  localparam logic [31:0] JAL_X0   = 32'h0050_006F; // bits[24:20]=5

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   id_inst, ex_target, pc_target;
  logic [4:0]    ex_rd;
  logic          ex_mem_read, ex_redirect, dmem_req, dmem_ready;
  logic          pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic          if_id_flush, id_ex_flush, mem_wb_flush, pc_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string         tag;
    logic [3:0]    we;
    logic [2:0]    fl;
    logic          sel;
    logic [31:0]   tgt;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .pc_sel(pc_sel), .pc_target(pc_target),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  task automatic idle();
    id_inst = NOP; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    ex_target = 32'd0; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Inputs are already driven; queue expectation, compare, advance to next negedge.
  task automatic step(input string tag, input logic [3:0] we, input logic [2:0] fl,
                      input logic sel, input logic [31:0] tgt);
    exp_t e, o;
    if (rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end
    e.tag = tag; e.we = we; e.fl = fl; e.sel = sel; e.tgt = tgt;
    e.sc = exp_stall; e.fc = exp_flush;
    sb.push_back(e);
    if (!rst) begin
      if (!we[3]) exp_stall = sat(exp_stall);
      if (sel)    exp_flush = sat(exp_flush);
    end
    #1;
    o = sb.pop_front();
    chk({o.tag, ".we"},  32'({pc_we, if_id_we, id_ex_we, ex_mem_we}), 32'(o.we));
    chk({o.tag, ".fl"},  32'({if_id_flush, id_ex_flush, mem_wb_flush}), 32'(o.fl));
    chk({o.tag, ".sel"}, 32'(pc_sel), 32'(o.sel));
    chk({o.tag, ".tgt"}, pc_target, o.tgt);
    chk({o.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(o.sc));
    chk({o.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(o.fc));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ex_redirect = 1'b1; ex_target = 32'hDEAD_BEEF;
    @(negedge clk);
    step("reset", WE_NONE, FL_RST, 1'b0, 32'd0);

    rst = 1'b0; idle();
    step("first_run", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // load-use on rs1, held through the stall cycle
    id_inst = ADD_156; ex_mem_read = 1'b1; ex_rd = 5'd5;
    step("lu_rs1", WE_LU, FL_LU, 1'b0, 32'd0);
    step("lu_rs1_after", WE_ALL, FL_NONE, 1'b0, 32'd0);
    idle();
    step("lu_rs1_norm", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // load-use on rs2
    id_inst = ADD_156; ex_mem_read = 1'b1; ex_rd = 5'd6;
    step("lu_rs2", WE_LU, FL_LU, 1'b0, 32'd0);
    idle();
    step("lu_rs2_after", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // no false hazards
    id_inst = LUI_X0; ex_mem_read = 1'b1; ex_rd = 5'd0;
    step("nohz_lui", WE_ALL, FL_NONE, 1'b0, 32'd0);
    id_inst = JAL_X0; ex_rd = 5'd5;
    step("nohz_jal", WE_ALL, FL_NONE, 1'b0, 32'd0);
    id_inst = 32'h0000_00B3; ex_rd = 5'd0; // add x1,x0,x0
    step("nohz_x0", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // redirect
    idle(); ex_redirect = 1'b1; ex_target = 32'h0000_0100;
    step("redir", WE_ALL, FL_RED, 1'b1, 32'h100);
    idle();
    step("redir_after", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // redirect overrides load-use
    id_inst = ADD_156; ex_mem_read = 1'b1; ex_rd = 5'd5;
    ex_redirect = 1'b1; ex_target = 32'h0000_0180;
    step("redir_lu", WE_ALL, FL_RED, 1'b1, 32'h180);
    idle();
    step("redir_lu_after", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // memory wait with redirect in the first frozen cycle
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 32'h0000_0200;
    step("mw_enter", WE_NONE, FL_MEM, 1'b0, 32'd0);
    ex_redirect = 1'b0; ex_target = 32'h0000_0999;
    step("mw_hold1", WE_NONE, FL_MEM, 1'b0, 32'd0);
    step("mw_hold2", WE_NONE, FL_MEM, 1'b0, 32'd0);
    dmem_ready = 1'b1;
    step("mw_done", WE_ALL, FL_RED, 1'b1, 32'h200);
    idle();
    step("mw_after", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // memory wait arriving during the load-use stall cycle
    id_inst = ADD_156; ex_mem_read = 1'b1; ex_rd = 5'd5;
    step("lu_then_mw", WE_LU, FL_LU, 1'b0, 32'd0);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step("lus_mw", WE_NONE, FL_MEM, 1'b0, 32'd0);
    dmem_ready = 1'b1;
    step("lus_mw_done", WE_ALL, FL_NONE, 1'b0, 32'd0);
    idle();
    step("lus_mw_after", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // saturation of both counters
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step("sat_stall", WE_NONE, FL_MEM, 1'b0, 32'd0);
    idle();
    step("sat_stall_done", WE_ALL, FL_NONE, 1'b0, 32'd0);
    ex_redirect = 1'b1; ex_target = 32'h0000_0040;
    for (int i = 0; i < 16; i++) step("sat_flush", WE_ALL, FL_RED, 1'b1, 32'h40);
    idle();
    step("sat_flush_done", WE_ALL, FL_NONE, 1'b0, 32'd0);

    // async reset while a redirect is pending in MEM_WAIT
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 32'h0000_0300;
    step("rmw_enter", WE_NONE, FL_MEM, 1'b0, 32'd0);
    ex_redirect = 1'b0;
    step("rmw_hold", WE_NONE, FL_MEM, 1'b0, 32'd0);
    rst = 1'b1;
    step("rmw_reset", WE_NONE, FL_RST, 1'b0, 32'd0);
    rst = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
    step("rmw_release", WE_ALL, FL_NONE, 1'b0, 32'd0);
    idle();
    step("rmw_after", WE_ALL, FL_NONE, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
